// File: rtl/regfile_onehot_wr_if.sv
// Bus bundle for the one-hot-write register file.
// master: the decoder/control side that drives the write select, data and read
// indices. slave: the register file itself.
interface regfile_onehot_wr_if #(
  parameter int DATA_WIDTH = 32
);
  logic [31:0]           WrSel;
  logic [DATA_WIDTH-1:0] WrData;
  logic [4:0]            RdAddrA;
  logic [4:0]            RdAddrB;
  logic [DATA_WIDTH-1:0] RdDataA;
  logic [DATA_WIDTH-1:0] RdDataB;
  logic                  ErrClr;
  logic                  WrErr;
  logic                  WrDone;

  modport master (
    output WrSel, WrData, RdAddrA, RdAddrB, ErrClr,
    input  RdDataA, RdDataB, WrErr, WrDone
  );

  modport slave (
    input  WrSel, WrData, RdAddrA, RdAddrB, ErrClr,
    output RdDataA, RdDataB, WrErr, WrDone
  );
endinterface

// File: rtl/regfile_onehot_wr.sv
// 32-entry register file written through a one-hot select bus.
// Multi-hot selects are detected explicitly and blocked, and they set a sticky
// WrErr flag. Both read ports are registered with one cycle of latency.
// Optional macro REGFILE_WR_BYPASS_EN: a legal write forwards its data to a
// read port addressing the same entry on the same edge. Without the macro,
// reads return the contents as they were before that edge's write.
module regfile_onehot_wr #(
  parameter int DATA_WIDTH = 32,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                Clk,
  input  logic                Rst,
  regfile_onehot_wr_if.slave  rf
);
  localparam int NUM_ENTRIES = 32;

  logic [DATA_WIDTH-1:0] mem [NUM_ENTRIES];
  logic                  any_sel;
  logic                  multi_sel;
  logic [4:0]            wr_idx;
  logic                  wr_legal;
  logic [DATA_WIDTH-1:0] rd_next_a;
  logic [DATA_WIDTH-1:0] rd_next_b;
  logic [DATA_WIDTH-1:0] rd_a_q;
  logic [DATA_WIDTH-1:0] rd_b_q;
  logic                  wr_err_q;
  logic                  wr_done_q;

  // Decode the select bus. Each index bit is the OR of all selected positions
  // that have that bit set, so no priority is involved. Multi-hot is flagged
  // when a set bit is found after an earlier set bit.
  always_comb begin
    any_sel   = 1'b0;
    multi_sel = 1'b0;
    wr_idx    = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      multi_sel = multi_sel | (any_sel & rf.WrSel[i]);
      any_sel   = any_sel | rf.WrSel[i];
      wr_idx    = wr_idx | ({5{rf.WrSel[i]}} & 5'(i));
    end
  end

  // A write counts only for exactly one selected entry that is not the
  // hardwired zero entry.
  assign wr_legal = any_sel && !multi_sel && !(ZERO_REG && (wr_idx == 5'd0));

  // Storage array. Entry 0 is never written while it is hardwired to zero.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_legal) begin
      mem[wr_idx] <= rf.WrData;
    end
  end

  // Next value for read port A. The zero override is applied last so that it
  // wins over both the stored value and the forwarded value.
  always_comb begin
    rd_next_a = mem[rf.RdAddrA];
`ifdef REGFILE_WR_BYPASS_EN
    if (wr_legal && (rf.RdAddrA == wr_idx)) begin
      rd_next_a = rf.WrData;
    end
`endif
    if (ZERO_REG && (rf.RdAddrA == 5'd0)) begin
      rd_next_a = '0;
    end
  end

  // Next value for read port B, built the same way as port A.
  always_comb begin
    rd_next_b = mem[rf.RdAddrB];
`ifdef REGFILE_WR_BYPASS_EN
    if (wr_legal && (rf.RdAddrB == wr_idx)) begin
      rd_next_b = rf.WrData;
    end
`endif
    if (ZERO_REG && (rf.RdAddrB == 5'd0)) begin
      rd_next_b = '0;
    end
  end

  // Registered read ports.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= rd_next_a;
      rd_b_q <= rd_next_b;
    end
  end

  // Sticky error flag. A new multi-hot select takes priority over a clear
  // on the same edge.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_err_q <= 1'b0;
    end else if (multi_sel) begin
      wr_err_q <= 1'b1;
    end else if (rf.ErrClr) begin
      wr_err_q <= 1'b0;
    end
  end

  // One-cycle pulse after each committed write.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_done_q <= 1'b0;
    end else begin
      wr_done_q <= wr_legal;
    end
  end

  assign rf.RdDataA = rd_a_q;
  assign rf.RdDataB = rd_b_q;
  assign rf.WrErr   = wr_err_q;
  assign rf.WrDone  = wr_done_q;

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Bench for regfile_onehot_wr. Two instances run side by side on identical
// stimulus: one with ZERO_REG=1 and one with ZERO_REG=0. A behavioural model
// (array plus popcount rules) checks every cycle. A hand-computed vector table
// and a few directed sequences cover the listed corner cases.
module tb_regfile_onehot_wr;
  localparam int DW = 32;
`ifdef REGFILE_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  regfile_onehot_wr_if #(.DATA_WIDTH(DW)) bus1 ();
  regfile_onehot_wr_if #(.DATA_WIDTH(DW)) bus0 ();

  regfile_onehot_wr #(.DATA_WIDTH(DW), .ZERO_REG(1'b1)) dut1 (
    .Clk (Clk), .Rst (Rst), .rf (bus1.slave)
  );
  regfile_onehot_wr #(.DATA_WIDTH(DW), .ZERO_REG(1'b0)) dut0 (
    .Clk (Clk), .Rst (Rst), .rf (bus0.slave)
  );

  int errors = 0;
  int checks = 0;

  // Model state: index 1 is the ZERO_REG=1 instance, index 0 is the other.
  logic [31:0] mm [2][32];
  logic [31:0] e_rda [2];
  logic [31:0] e_rdb [2];
  logic        e_err [2];
  logic        e_done [2];

  typedef struct {
    logic [31:0] sel;
    logic [31:0] data;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        clr;
    logic [31:0] rda1;
    logic [31:0] rdb1;
    logic [31:0] rda0;
    logic        err1;
    logic        done1;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] sel, input logic [31:0] data,
                       input logic [4:0] ra, input logic [4:0] rb, input logic clr);
    bus1.WrSel = sel; bus1.WrData = data; bus1.RdAddrA = ra; bus1.RdAddrB = rb; bus1.ErrClr = clr;
    bus0.WrSel = sel; bus0.WrData = data; bus0.RdAddrA = ra; bus0.RdAddrB = rb; bus0.ErrClr = clr;
  endtask

  task automatic model_reset();
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < 32; i++) mm[z][i] = '0;
      e_rda[z] = '0; e_rdb[z] = '0; e_err[z] = 1'b0; e_done[z] = 1'b0;
    end
  endtask

  function automatic logic [31:0] model_read(input int z, input logic [4:0] a, input bit legal,
                                             input int idx, input logic [31:0] data);
    if (z == 1 && a == 5'd0) return '0;
    if (BYP && legal && int'(a) == idx) return data;
    return mm[z][a];
  endfunction

  // Apply one rising edge to the model, using the inputs present on the bus.
  task automatic model_edge(input logic [31:0] sel, input logic [31:0] data,
                            input logic [4:0] ra, input logic [4:0] rb, input logic clr);
    int n;
    int idx;
    bit legal;
    n = $countones(sel);
    idx = -1;
    for (int i = 0; i < 32; i++) if (sel[i]) idx = i;
    for (int z = 0; z < 2; z++) begin
      legal = (n == 1) && !(z == 1 && idx == 0);
      e_rda[z] = model_read(z, ra, legal, idx, data);
      e_rdb[z] = model_read(z, rb, legal, idx, data);
      if (n >= 2) e_err[z] = 1'b1;
      else if (clr) e_err[z] = 1'b0;
      e_done[z] = legal;
      if (legal) mm[z][idx] = data;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " z1 RdDataA"}, bus1.RdDataA, e_rda[1]);
    chk({tag, " z1 RdDataB"}, bus1.RdDataB, e_rdb[1]);
    chk({tag, " z1 WrErr"},   32'(bus1.WrErr),  32'(e_err[1]));
    chk({tag, " z1 WrDone"},  32'(bus1.WrDone), 32'(e_done[1]));
    chk({tag, " z0 RdDataA"}, bus0.RdDataA, e_rda[0]);
    chk({tag, " z0 RdDataB"}, bus0.RdDataB, e_rdb[0]);
    chk({tag, " z0 WrErr"},   32'(bus0.WrErr),  32'(e_err[0]));
    chk({tag, " z0 WrDone"},  32'(bus0.WrDone), 32'(e_done[0]));
  endtask

  // Drive inputs, take one rising edge, then sample 1 time unit later.
  task automatic cycle(input string tag, input logic [31:0] sel, input logic [31:0] data,
                       input logic [4:0] ra, input logic [4:0] rb, input logic clr);
    drive(sel, data, ra, rb, clr);
    @(posedge Clk);
    model_edge(sel, data, ra, rb, clr);
    #1;
    check_all(tag);
  endtask

  initial begin
    // Hand-computed expectations, starting from an all-zero file.
    tbl[0]  = '{32'h0000_0020, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1};
    tbl[1]  = '{32'h0, 32'h0, 5'd0, 5'd5, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0};
    tbl[2]  = '{32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 5'd5, 1'b0, 32'h0, 32'hDEAD_BEEF,
                (BYP ? 32'hFFFF_FFFF : 32'h0), 1'b0, 1'b0};
    tbl[3]  = '{32'h0, 32'h0, 5'd0, 5'd5, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[4]  = '{32'h0000_0008, 32'h1111_1111, 5'd3, 5'd4, 1'b0, (BYP ? 32'h1111_1111 : 32'h0),
                32'h0, (BYP ? 32'h1111_1111 : 32'h0), 1'b0, 1'b1};
    tbl[5]  = '{32'h0000_0018, 32'h1234_5678, 5'd3, 5'd4, 1'b0, 32'h1111_1111, 32'h0,
                32'h1111_1111, 1'b1, 1'b0};
    tbl[6]  = '{32'h0, 32'h0, 5'd3, 5'd4, 1'b0, 32'h1111_1111, 32'h0, 32'h1111_1111, 1'b1, 1'b0};
    tbl[7]  = '{32'h0, 32'h0, 5'd3, 5'd4, 1'b1, 32'h1111_1111, 32'h0, 32'h1111_1111, 1'b0, 1'b0};
    tbl[8]  = '{32'h8000_0001, 32'h5555_5555, 5'd31, 5'd0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0};
    tbl[9]  = '{32'h0000_0200, 32'h0000_0001, 5'd9, 5'd9, 1'b0, (BYP ? 32'h1 : 32'h0),
                (BYP ? 32'h1 : 32'h0), (BYP ? 32'h1 : 32'h0), 1'b1, 1'b1};
    tbl[10] = '{32'h0000_0200, 32'hA5A5_A5A5, 5'd9, 5'd9, 1'b1, (BYP ? 32'hA5A5_A5A5 : 32'h1),
                (BYP ? 32'hA5A5_A5A5 : 32'h1), (BYP ? 32'hA5A5_A5A5 : 32'h1), 1'b0, 1'b1};
    tbl[11] = '{32'h0, 32'h0, 5'd9, 5'd9, 1'b0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5,
                1'b0, 1'b0};

    // Reset state.
    drive('0, '0, '0, '0, 1'b0);
    Rst = 1'b1;
    model_reset();
    #12;
    check_all("reset");
    @(negedge Clk);
    Rst = 1'b0;

    // Every address reads zero after reset.
    for (int i = 0; i < 32; i++) cycle($sformatf("rd0_%0d", i), '0, '0, 5'(i), 5'(31 - i), 1'b0);

    // Vector table.
    for (int k = 0; k < 12; k++) begin
      cycle($sformatf("tbl%0d", k), tbl[k].sel, tbl[k].data, tbl[k].ra, tbl[k].rb, tbl[k].clr);
      chk($sformatf("tbl%0d rda1", k), bus1.RdDataA, tbl[k].rda1);
      chk($sformatf("tbl%0d rdb1", k), bus1.RdDataB, tbl[k].rdb1);
      chk($sformatf("tbl%0d rda0", k), bus0.RdDataA, tbl[k].rda0);
      chk($sformatf("tbl%0d err1", k), 32'(bus1.WrErr), 32'(tbl[k].err1));
      chk($sformatf("tbl%0d done1", k), 32'(bus1.WrDone), 32'(tbl[k].done1));
    end

    // Asynchronous reset between edges, with an error pending and a write
    // to entry 31 just committed.
    cycle("pre_rst_err", 32'h0000_0003, 32'h0, 5'd31, 5'd31, 1'b0);
    cycle("pre_rst_w1", 32'h8000_0000, 32'hCAFE_0000, 5'd31, 5'd31, 1'b0);
    cycle("pre_rst_w2", 32'h8000_0000, 32'hCAFE_0000, 5'd31, 5'd31, 1'b0);
    chk("pre_rst rdA", bus1.RdDataA, 32'hCAFE_0000);
    chk("pre_rst done", 32'(bus1.WrDone), 32'h1);
    chk("pre_rst err", 32'(bus1.WrErr), 32'h1);
    #2;
    Rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    chk("async_rst rdB", bus0.RdDataB, 32'h0);
    @(negedge Clk);
    check_all("rst_held");
    Rst = 1'b0;
    cycle("post_rst31", '0, '0, 5'd31, 5'd31, 1'b0);
    chk("post_rst31 rdA", bus1.RdDataA, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] sel;
      logic [31:0] data;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic        clr;
      int          r;
      int          a;
      int          b;
      r = $urandom_range(0, 9);
      a = $urandom_range(0, 31);
      b = (a + 1 + $urandom_range(0, 30)) % 32;
      if (r < 2) sel = '0;
      else if (r < 7) sel = 32'(1) << a;
      else if (r < 9) sel = (32'(1) << a) | (32'(1) << b);
      else sel = $urandom;
      data = $urandom;
      ra = ($urandom_range(0, 2) == 0) ? 5'(a) : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 2) == 0) ? 5'(a) : 5'($urandom_range(0, 31));
      clr = ($urandom_range(0, 7) == 0);
      cycle($sformatf("rnd%0d", n), sel, data, ra, rb, clr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
